vend_ctrl_mp: RTL and testbench
===============================

Name: vend_ctrl_mp

Overview:
Parametrised multi-product vending controller, the successor to the single-product soda dispenser FSM. It accepts one-hot nickel/dime/quarter coin pulses (4/2/1 encoding kept), accumulates credit, and vends a selected product when credit ≥ PRICE and stock > 0. It then returns change one coin per cycle, largest coin first. The block adds cancel/refund, per-channel stock tracking, restock, coin rejection and an auto-vend mode, and sits between the coin acceptor front end and the dispenser/change actuators.

Parameters:
PRICE, 25, product price in cents; must be a multiple of 5 and ≤ MAX_CREDIT.
MAX_CREDIT, 50, credit ceiling in cents; must be a multiple of 5.
NUM_PROD, 4, number of product channels (≥1).
STOCK_MAX, 7, items per channel after restock (≥1).
AUTO_VEND, 0, 1 = channel 0 vends automatically when credit ≥ PRICE, with no selection needed (legacy single-product mode).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
coin_in  in  3  one-hot coin pulse: 3'b100 nickel, 3'b010 dime, 3'b001 quarter, 0 none
sel_valid  in  1  product selection strobe
sel_idx  in  IW=max(1,$clog2(NUM_PROD))  selected channel
cancel  in  1  refund request
restock  in  1  restock strobe
restock_idx  in  IW  channel to refill
dis  out  1  dispense pulse
dis_idx  out  IW  channel dispensed (valid when dis=1)
chg_n  out  1  return one nickel
chg_d  out  1  return one dime
coin_rej  out  1  coin refused / returned
sel_err  out  1  selection refused
busy  out  1  high in VEND or CHANGE
credit  out  CW=$clog2(MAX_CREDIT/5+1)  current credit in 5-cent units
empty  out  NUM_PROD  per-channel stock==0

Behaviour:
- Async reset: state IDLE; credit=0; every stock counter = STOCK_MAX; all pulse outputs 0; dis_idx=0; empty=0.
- All outputs are registered. Pulses last exactly one cycle.
- Units: nickel=1, dime=2, quarter=5. PRICE_U=PRICE/5. Change remainder rem has width CW.
- States:
  - IDLE: credit==0.
  - COLLECT: credit>0.
  - VEND.
  - CHANGE.
- Coin handling in IDLE/COLLECT, for a valid one-hot coin:
  - If credit+value ≤ MAX_CREDIT/5, credit updates on the next edge and the state becomes COLLECT.
  - Otherwise coin_rej pulses the next cycle and credit is unchanged.
- Non-one-hot nonzero coin_in in any state: coin_rej, no credit change.
- Any coin while busy: coin_rej.
- Selection (IDLE/COLLECT): evaluated against the registered credit, i.e. before a same-cycle coin.
  - Accept if credit ≥ PRICE_U, sel_idx < NUM_PROD, and stock[sel_idx] > 0. Next state is VEND.
  - If accepted, a coin in the same cycle is rejected (coin_rej).
  - Otherwise sel_err pulses and the state is unchanged.
- AUTO_VEND=1: in COLLECT with credit ≥ PRICE_U, go to VEND on channel 0 without sel_valid. sel_valid is still honoured.
  - If channel 0 is empty, stay in COLLECT; cancel refunds.
- VEND (one cycle):
  - dis=1, dis_idx=channel.
  - stock decrements.
  - rem = credit − PRICE_U; credit ← rem.
  - Next state is CHANGE if rem>0, else IDLE.
- Cancel in COLLECT: go to CHANGE with rem=credit, no dis. Cancel beats a same-cycle selection. Cancel in IDLE or while busy is ignored.
- CHANGE, one coin per cycle:
  - rem ≥ 2: chg_d, rem −= 2.
  - else: chg_n, rem −= 1.
  - credit tracks rem. When rem reaches 0, go to IDLE the same edge.
- Restock: accepted in any state. Stock[restock_idx] ← STOCK_MAX. restock_idx ≥ NUM_PROD is ignored.
  - Restock beats a same-cycle decrement of the same channel.
- empty updates one cycle after the stock change.
- Async reset mid-VEND/CHANGE aborts immediately. No dis or change completes, and credit is lost.

Decomposition:
- Package vend_pkg:
  - state enum {S_IDLE, S_COLLECT, S_VEND, S_CHANGE};
  - coin encodings COIN_N=3'b100, COIN_D=3'b010, COIN_Q=3'b001;
  - unit values 1/2/5.
- Sub-module vend_stock: NUM_PROD saturating stock counters with decrement/restock and empty flags.
- Controller FSM and credit datapath stay in vend_ctrl_mp.

Test Plan:
Defaults are used unless a scenario states otherwise; count cycles from the accept edge.

1. AUTO_VEND=1, NUM_PROD=1: five nickels on consecutive cycles → credit 1..5; dis one cycle after the 5th accept; no chg; back to IDLE, credit 0.
2. AUTO_VEND=1: nickel, quarter → credit 6 → dis, then chg_n ×1 → IDLE.
3. AUTO_VEND=1: nickel, dime, nickel, quarter (credit 9) → dis, then chg_d, chg_d on consecutive cycles → IDLE.
4. AUTO_VEND=0: dime, quarter (7) then sel_idx=2 → dis with dis_idx=2, stock[2]=6, chg_d ×1. Next, sel while credit 0 → sel_err, and coin during CHANGE → coin_rej.
5. Quarters to 50 cents, then a third quarter → coin_rej, credit stays 10. cancel → chg_d ×5 → IDLE. Also coin_in=3'b110 → coin_rej.
6. Vend channel 1 seven times → empty[1]=1. Next sel 1 → sel_err. restock idx 1 → empty[1]=0. rst asserted during CHANGE → all outputs 0 asynchronously, credit 0.

Source files
------------

// File: rtl/vend_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// vend_pkg : shared types, coin encodings and unit values for vending
// Rev 1.0
// ------------------------------------------------------------------
package vend_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_VEND    = 2'd2,
    S_CHANGE  = 2'd3
  } state_t;

  localparam logic [2:0] COIN_N = 3'b100;
  localparam logic [2:0] COIN_D = 3'b010;
  localparam logic [2:0] COIN_Q = 3'b001;

  // Coin values in 5-cent units.
  localparam logic [2:0] VAL_N = 3'd1;
  localparam logic [2:0] VAL_D = 3'd2;
  localparam logic [2:0] VAL_Q = 3'd5;

  function automatic logic coin_valid(input logic [2:0] coin);
    return (coin == COIN_N) || (coin == COIN_D) || (coin == COIN_Q);
  endfunction

  function automatic logic [2:0] coin_value(input logic [2:0] coin);
    case (coin)
      COIN_N:  return VAL_N;
      COIN_D:  return VAL_D;
      COIN_Q:  return VAL_Q;
      default: return 3'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/vend_stock.sv
`default_nettype none
// ------------------------------------------------------------------
// vend_stock : per-channel saturating stock counters with empty flags
// Rev 1.0
// ------------------------------------------------------------------
module vend_stock #(
  parameter int NUM_PROD  = 4,
  parameter int STOCK_MAX = 7,
  parameter int IW        = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                dec,
  input  logic [IW-1:0]       dec_idx,
  input  logic                restock,
  input  logic [IW-1:0]       restock_idx,
  output logic [NUM_PROD-1:0] has_stock,
  output logic [NUM_PROD-1:0] empty
);

  localparam int SW = $clog2(STOCK_MAX + 1);
  localparam logic [SW-1:0] FULL = SW'(STOCK_MAX);

  logic [NUM_PROD-1:0][SW-1:0] cnt;

  // Restock has priority over a same-cycle decrement of the same channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PROD; i++) begin
        cnt[i]   <= FULL;
        empty[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_PROD; i++) begin
        if (restock && (restock_idx == IW'(i))) begin
          cnt[i] <= FULL;
        end else if (dec && (dec_idx == IW'(i)) && (cnt[i] != '0)) begin
          cnt[i] <= cnt[i] - SW'(1);
        end
        empty[i] <= (cnt[i] == '0);
      end
    end
  end

  always_comb begin
    has_stock = '0;
    for (int i = 0; i < NUM_PROD; i++) begin
      has_stock[i] = (cnt[i] != '0);
    end
  end

endmodule
`default_nettype wire

// File: rtl/vend_ctrl_mp.sv
`default_nettype none
// ------------------------------------------------------------------
// vend_ctrl_mp : multi-product vending controller, credit and change FSM
// Rev 1.0
// ------------------------------------------------------------------
module vend_ctrl_mp
  import vend_pkg::*;
#(
  parameter int PRICE      = 25,
  parameter int MAX_CREDIT = 50,
  parameter int NUM_PROD   = 4,
  parameter int STOCK_MAX  = 7,
  parameter int AUTO_VEND  = 0,
  localparam int IW = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1,
  localparam int CW = $clog2(MAX_CREDIT / 5 + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          coin_in,
  input  logic                sel_valid,
  input  logic [IW-1:0]       sel_idx,
  input  logic                cancel,
  input  logic                restock,
  input  logic [IW-1:0]       restock_idx,
  output logic                dis,
  output logic [IW-1:0]       dis_idx,
  output logic                chg_n,
  output logic                chg_d,
  output logic                coin_rej,
  output logic                sel_err,
  output logic                busy,
  output logic [CW-1:0]       credit,
  output logic [NUM_PROD-1:0] empty
);

  localparam logic [CW-1:0]   PRICE_U = CW'(PRICE / 5);
  localparam logic [CW+2:0]   MAX_U   = (CW + 3)'(MAX_CREDIT / 5);

  state_t              state, state_nxt;
  logic [CW-1:0]       credit_nxt;
  logic                dis_nxt, chg_n_nxt, chg_d_nxt, coin_rej_nxt, sel_err_nxt;
  logic [IW-1:0]       dis_idx_nxt;
  logic                go_vend, coin_ok;
  logic [CW+2:0]       sum;
  logic [NUM_PROD-1:0] has_stock;
  logic [2**IW-1:0]    stock_ok;

  // Out-of-range selections land on padding bits that read as out of stock.
  always_comb begin
    stock_ok                = '0;
    stock_ok[NUM_PROD-1:0]  = has_stock;
  end

  assign coin_ok = coin_valid(coin_in);
  assign sum     = (CW + 3)'(credit) + (CW + 3)'(coin_value(coin_in));

  always_comb begin
    state_nxt    = state;
    credit_nxt   = credit;
    dis_nxt      = 1'b0;
    dis_idx_nxt  = dis_idx;
    chg_n_nxt    = 1'b0;
    chg_d_nxt    = 1'b0;
    coin_rej_nxt = 1'b0;
    sel_err_nxt  = 1'b0;
    go_vend      = 1'b0;

    if ((coin_in != 3'b000) && !coin_ok) begin
      coin_rej_nxt = 1'b1;
    end

    case (state)
      S_IDLE, S_COLLECT: begin
        // Selection is judged on registered credit, ahead of any same-cycle coin.
        if (cancel && (state == S_COLLECT)) begin
          state_nxt = S_CHANGE;
        end else if (sel_valid) begin
          if ((credit >= PRICE_U) && stock_ok[sel_idx]) begin
            go_vend     = 1'b1;
            dis_idx_nxt = sel_idx;
          end else begin
            sel_err_nxt = 1'b1;
          end
        end else if ((AUTO_VEND != 0) && (state == S_COLLECT) &&
                     (credit >= PRICE_U) && stock_ok[0]) begin
          go_vend     = 1'b1;
          dis_idx_nxt = '0;
        end

        if (go_vend) begin
          state_nxt = S_VEND;
          dis_nxt   = 1'b1;
        end

        if (coin_ok) begin
          if ((state_nxt == S_VEND) || (state_nxt == S_CHANGE) || (sum > MAX_U)) begin
            coin_rej_nxt = 1'b1;
          end else begin
            credit_nxt = sum[CW-1:0];
            state_nxt  = S_COLLECT;
          end
        end
      end

      S_VEND: begin
        if (coin_in != 3'b000) coin_rej_nxt = 1'b1;
        credit_nxt = credit - PRICE_U;
        state_nxt  = (credit == PRICE_U) ? S_IDLE : S_CHANGE;
      end

      S_CHANGE: begin
        if (coin_in != 3'b000) coin_rej_nxt = 1'b1;
        if (credit >= CW'(2)) begin
          chg_d_nxt  = 1'b1;
          credit_nxt = credit - CW'(2);
        end else if (credit != '0) begin
          chg_n_nxt  = 1'b1;
          credit_nxt = credit - CW'(1);
        end
        if (credit_nxt == '0) state_nxt = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit   <= '0;
      dis      <= 1'b0;
      dis_idx  <= '0;
      chg_n    <= 1'b0;
      chg_d    <= 1'b0;
      coin_rej <= 1'b0;
      sel_err  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      credit   <= credit_nxt;
      dis      <= dis_nxt;
      dis_idx  <= dis_idx_nxt;
      chg_n    <= chg_n_nxt;
      chg_d    <= chg_d_nxt;
      coin_rej <= coin_rej_nxt;
      sel_err  <= sel_err_nxt;
      busy     <= (state_nxt == S_VEND) || (state_nxt == S_CHANGE);
    end
  end

  // dis_idx holds the vending channel through the VEND cycle.
  vend_stock #(
    .NUM_PROD  (NUM_PROD),
    .STOCK_MAX (STOCK_MAX),
    .IW        (IW)
  ) u_stock (
    .clk         (clk),
    .rst         (rst),
    .dec         (state == S_VEND),
    .dec_idx     (dis_idx),
    .restock     (restock),
    .restock_idx (restock_idx),
    .has_stock   (has_stock),
    .empty       (empty)
  );

endmodule
`default_nettype wire

// File: tb/tb_vend_ctrl_mp.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_vend_ctrl_mp : directed self-checking bench for vend_ctrl_mp
// Rev 1.0
// ------------------------------------------------------------------
module tb_vend_ctrl_mp;
  import vend_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // A: auto-vend single product; B: auto-vend default channels (shared stimulus).
  logic [2:0] ab_coin   = 3'b000;
  logic       ab_cancel = 1'b0;

  logic       a_dis, a_chg_n, a_chg_d, a_coin_rej, a_sel_err, a_busy;
  logic [0:0] a_dis_idx, a_empty;
  logic [3:0] a_credit;

  logic       b_dis, b_chg_n, b_chg_d, b_coin_rej, b_sel_err, b_busy;
  logic [1:0] b_dis_idx;
  logic [3:0] b_empty, b_credit;

  // C: selection mode, default parameters.
  logic [2:0] c_coin = 3'b000;
  logic       c_sel_valid = 1'b0, c_cancel = 1'b0, c_restock = 1'b0;
  logic [1:0] c_sel_idx = 2'd0, c_restock_idx = 2'd0;
  logic       c_dis, c_chg_n, c_chg_d, c_coin_rej, c_sel_err, c_busy;
  logic [1:0] c_dis_idx;
  logic [3:0] c_empty, c_credit;

  vend_ctrl_mp #(.AUTO_VEND(1), .NUM_PROD(1)) dut_a (
    .clk(clk), .rst(rst), .coin_in(ab_coin), .sel_valid(1'b0), .sel_idx(1'b0),
    .cancel(ab_cancel), .restock(1'b0), .restock_idx(1'b0),
    .dis(a_dis), .dis_idx(a_dis_idx), .chg_n(a_chg_n), .chg_d(a_chg_d),
    .coin_rej(a_coin_rej), .sel_err(a_sel_err), .busy(a_busy),
    .credit(a_credit), .empty(a_empty)
  );

  vend_ctrl_mp #(.AUTO_VEND(1)) dut_b (
    .clk(clk), .rst(rst), .coin_in(ab_coin), .sel_valid(1'b0), .sel_idx(2'd0),
    .cancel(ab_cancel), .restock(1'b0), .restock_idx(2'd0),
    .dis(b_dis), .dis_idx(b_dis_idx), .chg_n(b_chg_n), .chg_d(b_chg_d),
    .coin_rej(b_coin_rej), .sel_err(b_sel_err), .busy(b_busy),
    .credit(b_credit), .empty(b_empty)
  );

  vend_ctrl_mp dut_c (
    .clk(clk), .rst(rst), .coin_in(c_coin), .sel_valid(c_sel_valid), .sel_idx(c_sel_idx),
    .cancel(c_cancel), .restock(c_restock), .restock_idx(c_restock_idx),
    .dis(c_dis), .dis_idx(c_dis_idx), .chg_n(c_chg_n), .chg_d(c_chg_d),
    .coin_rej(c_coin_rej), .sel_err(c_sel_err), .busy(c_busy),
    .credit(c_credit), .empty(c_empty)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    total++;
    if ({a_dis, a_chg_n, a_chg_d, a_coin_rej, a_sel_err, a_busy, a_credit} !== 10'd0) begin
      bad++; $display("FAIL reset_a got=%b want=0", {a_dis, a_chg_n, a_chg_d, a_coin_rej, a_sel_err, a_busy, a_credit});
    end
    total++;
    if ({c_dis, c_dis_idx, c_chg_n, c_chg_d, c_coin_rej, c_sel_err, c_busy, c_credit, c_empty} !== 16'd0) begin
      bad++; $display("FAIL reset_c got=%b want=0", {c_dis, c_dis_idx, c_chg_n, c_chg_d, c_coin_rej, c_sel_err, c_busy, c_credit, c_empty});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_auto_nickels();
    for (int i = 1; i <= 5; i++) begin
      ab_coin = COIN_N;
      tick();
      total++;
      if (a_credit !== 4'(i)) begin
        bad++; $display("FAIL t1_credit step=%0d got=%0d want=%0d", i, a_credit, i);
      end
    end
    ab_coin = 3'b000;
    tick();
    total++;
    if (a_dis !== 1'b1 || a_dis_idx !== 1'b0 || a_busy !== 1'b1) begin
      bad++; $display("FAIL t1_dis got dis=%b idx=%0d busy=%b want 1/0/1", a_dis, a_dis_idx, a_busy);
    end
    tick();
    total++;
    if (a_dis !== 1'b0 || a_credit !== 4'd0 || a_busy !== 1'b0 || a_chg_n !== 1'b0 || a_chg_d !== 1'b0) begin
      bad++; $display("FAIL t1_idle got dis=%b credit=%0d busy=%b chg=%b%b want 0/0/0/00",
                      a_dis, a_credit, a_busy, a_chg_n, a_chg_d);
    end
    tick();
    total++;
    if (a_chg_n !== 1'b0 || a_chg_d !== 1'b0) begin
      bad++; $display("FAIL t1_nochg got chg_n=%b chg_d=%b want 0/0", a_chg_n, a_chg_d);
    end
  endtask

  task automatic test_auto_change_n();
    ab_coin = COIN_N; tick();
    ab_coin = COIN_Q; tick();
    total++;
    if (b_credit !== 4'd6) begin
      bad++; $display("FAIL t2_credit got=%0d want=6", b_credit);
    end
    ab_coin = 3'b000; tick();
    total++;
    if (b_dis !== 1'b1 || b_dis_idx !== 2'd0) begin
      bad++; $display("FAIL t2_dis got dis=%b idx=%0d want 1/0", b_dis, b_dis_idx);
    end
    tick();
    total++;
    if (b_credit !== 4'd1 || b_busy !== 1'b1 || b_dis !== 1'b0) begin
      bad++; $display("FAIL t2_rem got credit=%0d busy=%b dis=%b want 1/1/0", b_credit, b_busy, b_dis);
    end
    tick();
    total++;
    if (b_chg_n !== 1'b1 || b_chg_d !== 1'b0 || b_credit !== 4'd0 || b_busy !== 1'b0) begin
      bad++; $display("FAIL t2_chg got chg_n=%b chg_d=%b credit=%0d busy=%b want 1/0/0/0",
                      b_chg_n, b_chg_d, b_credit, b_busy);
    end
    tick();
    total++;
    if (b_chg_n !== 1'b0) begin
      bad++; $display("FAIL t2_pulse got chg_n=%b want 0", b_chg_n);
    end
  endtask

  task automatic test_auto_change_d();
    ab_coin = COIN_N; tick();
    ab_coin = COIN_D; tick();
    ab_coin = COIN_N; tick();
    ab_coin = COIN_Q; tick();
    total++;
    if (b_credit !== 4'd9) begin
      bad++; $display("FAIL t3_credit got=%0d want=9", b_credit);
    end
    ab_coin = 3'b000; tick();
    total++;
    if (b_dis !== 1'b1) begin
      bad++; $display("FAIL t3_dis got=%b want=1", b_dis);
    end
    tick();
    total++;
    if (b_credit !== 4'd4) begin
      bad++; $display("FAIL t3_rem got=%0d want=4", b_credit);
    end
    tick();
    total++;
    if (b_chg_d !== 1'b1 || b_chg_n !== 1'b0 || b_credit !== 4'd2) begin
      bad++; $display("FAIL t3_chg1 got chg_d=%b chg_n=%b credit=%0d want 1/0/2", b_chg_d, b_chg_n, b_credit);
    end
    tick();
    total++;
    if (b_chg_d !== 1'b1 || b_chg_n !== 1'b0 || b_credit !== 4'd0 || b_busy !== 1'b0) begin
      bad++; $display("FAIL t3_chg2 got chg_d=%b chg_n=%b credit=%0d busy=%b want 1/0/0/0",
                      b_chg_d, b_chg_n, b_credit, b_busy);
    end
    tick();
    total++;
    if (b_chg_d !== 1'b0 || b_chg_n !== 1'b0) begin
      bad++; $display("FAIL t3_end got chg_d=%b chg_n=%b want 0/0", b_chg_d, b_chg_n);
    end
  endtask

  task automatic test_select();
    c_coin = COIN_D; tick();
    c_coin = COIN_Q; tick();
    c_coin = 3'b000;
    total++;
    if (c_credit !== 4'd7) begin
      bad++; $display("FAIL t4_credit got=%0d want=7", c_credit);
    end
    c_sel_valid = 1'b1; c_sel_idx = 2'd2; tick();
    c_sel_valid = 1'b0;
    total++;
    if (c_dis !== 1'b1 || c_dis_idx !== 2'd2) begin
      bad++; $display("FAIL t4_dis got dis=%b idx=%0d want 1/2", c_dis, c_dis_idx);
    end
    tick();
    total++;
    if (c_credit !== 4'd2 || c_busy !== 1'b1 || dut_c.u_stock.cnt[2] !== 3'd6) begin
      bad++; $display("FAIL t4_vend got credit=%0d busy=%b stock2=%0d want 2/1/6",
                      c_credit, c_busy, dut_c.u_stock.cnt[2]);
    end
    c_coin = COIN_N; tick();
    c_coin = 3'b000;
    total++;
    if (c_chg_d !== 1'b1 || c_coin_rej !== 1'b1 || c_credit !== 4'd0) begin
      bad++; $display("FAIL t4_chg got chg_d=%b coin_rej=%b credit=%0d want 1/1/0", c_chg_d, c_coin_rej, c_credit);
    end
    c_sel_valid = 1'b1; c_sel_idx = 2'd0; tick();
    c_sel_valid = 1'b0;
    total++;
    if (c_sel_err !== 1'b1 || c_dis !== 1'b0 || c_chg_d !== 1'b0) begin
      bad++; $display("FAIL t4_selerr got sel_err=%b dis=%b chg_d=%b want 1/0/0", c_sel_err, c_dis, c_chg_d);
    end
    tick();
  endtask

  task automatic test_overflow_cancel();
    int nd;
    c_coin = COIN_Q; tick();
    c_coin = COIN_Q; tick();
    c_coin = COIN_Q; tick();
    c_coin = 3'b000;
    total++;
    if (c_coin_rej !== 1'b1 || c_credit !== 4'd10) begin
      bad++; $display("FAIL t5_over got coin_rej=%b credit=%0d want 1/10", c_coin_rej, c_credit);
    end
    c_cancel = 1'b1; tick();
    c_cancel = 1'b0;
    total++;
    if (c_busy !== 1'b1 || c_credit !== 4'd10 || c_dis !== 1'b0 || c_chg_d !== 1'b0) begin
      bad++; $display("FAIL t5_cancel got busy=%b credit=%0d dis=%b chg_d=%b want 1/10/0/0",
                      c_busy, c_credit, c_dis, c_chg_d);
    end
    nd = 0;
    repeat (5) begin
      tick();
      if (c_chg_d === 1'b1 && c_chg_n === 1'b0) nd++;
    end
    total++;
    if (nd !== 5 || c_credit !== 4'd0 || c_busy !== 1'b0) begin
      bad++; $display("FAIL t5_refund got dimes=%0d credit=%0d busy=%b want 5/0/0", nd, c_credit, c_busy);
    end
    tick();
    total++;
    if (c_chg_d !== 1'b0 || c_chg_n !== 1'b0) begin
      bad++; $display("FAIL t5_end got chg_d=%b chg_n=%b want 0/0", c_chg_d, c_chg_n);
    end
    c_coin = 3'b110; tick();
    c_coin = 3'b000;
    total++;
    if (c_coin_rej !== 1'b1 || c_credit !== 4'd0) begin
      bad++; $display("FAIL t5_bad_coin got coin_rej=%b credit=%0d want 1/0", c_coin_rej, c_credit);
    end
    tick();
  endtask

  task automatic test_empty_restock();
    int nv;
    nv = 0;
    for (int k = 0; k < 7; k++) begin
      c_coin = COIN_Q; tick();
      c_coin = 3'b000;
      c_sel_valid = 1'b1; c_sel_idx = 2'd1; tick();
      c_sel_valid = 1'b0;
      if (c_dis === 1'b1 && c_dis_idx === 2'd1) nv++;
      tick();
    end
    total++;
    if (nv !== 7 || c_empty[1] !== 1'b0 || c_credit !== 4'd0) begin
      bad++; $display("FAIL t6_vends got vends=%0d empty1=%b credit=%0d want 7/0/0", nv, c_empty[1], c_credit);
    end
    tick();
    total++;
    if (c_empty !== 4'b0010) begin
      bad++; $display("FAIL t6_empty got=%b want=0010", c_empty);
    end
    c_coin = COIN_Q; tick();
    c_coin = 3'b000;
    c_sel_valid = 1'b1; c_sel_idx = 2'd1; tick();
    c_sel_valid = 1'b0;
    total++;
    if (c_sel_err !== 1'b1 || c_dis !== 1'b0 || c_credit !== 4'd5) begin
      bad++; $display("FAIL t6_selerr got sel_err=%b dis=%b credit=%0d want 1/0/5", c_sel_err, c_dis, c_credit);
    end
    c_restock = 1'b1; c_restock_idx = 2'd1; tick();
    c_restock = 1'b0;
    tick();
    total++;
    if (c_empty !== 4'b0000) begin
      bad++; $display("FAIL t6_restock got=%b want=0000", c_empty);
    end
    c_cancel = 1'b1; tick();
    c_cancel = 1'b0;
    tick();
    total++;
    if (c_chg_d !== 1'b1 || c_credit !== 4'd3 || c_busy !== 1'b1) begin
      bad++; $display("FAIL t6_midchg got chg_d=%b credit=%0d busy=%b want 1/3/1", c_chg_d, c_credit, c_busy);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({c_dis, c_chg_n, c_chg_d, c_coin_rej, c_sel_err, c_busy, c_credit, c_empty} !== 14'd0) begin
      bad++; $display("FAIL t6_async_rst got=%b want=0", {c_dis, c_chg_n, c_chg_d, c_coin_rej, c_sel_err, c_busy, c_credit, c_empty});
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    total++;
    if (c_chg_n !== 1'b0 || c_chg_d !== 1'b0 || c_credit !== 4'd0) begin
      bad++; $display("FAIL t6_post_rst got chg_n=%b chg_d=%b credit=%0d want 0/0/0", c_chg_n, c_chg_d, c_credit);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_auto_nickels();
    test_auto_change_n();
    test_auto_change_d();
    test_select();
    test_overflow_cancel();
    test_empty_restock();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
